// File: rtl/zet_fetch_prefetch.sv
// Instruction prefetch queue for the Zet fetch stage: reads sequential 16-bit
// words over Wishbone into a small first-word-fall-through FIFO tagged with addresses.
module zet_fetch_prefetch #(
   parameter int          DEPTH_LOG2 = 2,
   parameter logic [18:0] RESET_ADR  = 19'h7FFF8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [18:0]           flush_adr_i,
   input  logic                  rd_i,
   output logic                  q_valid_o,
   output logic [15:0]           q_dat_o,
   output logic [18:0]           q_adr_o,
   output logic [DEPTH_LOG2:0]   q_count_o,
   output logic [18:0]           wbm_adr_o,
   output logic [1:0]            wbm_sel_o,
   output logic                  wbm_cyc_o,
   output logic                  wbm_stb_o,
   input  logic [15:0]           wbm_dat_i,
   input  logic                  wbm_ack_i
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t                state_reg;
   logic [18:0]           fetch_adr_reg;
   logic [18:0]           wbm_adr_reg;
   logic                  cyc_reg;

   logic [15:0]           dat_mem [DEPTH];
   logic [18:0]           adr_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg;

   logic push;
   logic pop;
   logic issue;

   // Flush outranks both push and pop; data acked during a flush is dropped.
   always_comb begin
      push  = (state_reg == REQ) && wbm_ack_i && !flush_i;
      pop   = rd_i && (count_reg != '0) && !flush_i;
      issue = (state_reg == IDLE) && !flush_i && (count_reg < FULL_COUNT);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         cyc_reg       <= 1'b0;
         fetch_adr_reg <= RESET_ADR;
         wbm_adr_reg   <= RESET_ADR;
      end else begin
         case (state_reg)
            IDLE: begin
               if (flush_i) begin
                  fetch_adr_reg <= flush_adr_i;
               end else if (issue) begin
                  wbm_adr_reg <= fetch_adr_reg;
                  cyc_reg     <= 1'b1;
                  state_reg   <= REQ;
               end
            end
            REQ: begin
               if (flush_i) begin
                  fetch_adr_reg <= flush_adr_i;
                  if (wbm_ack_i) begin
                     cyc_reg   <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     state_reg <= DRAIN;
                  end
               end else if (wbm_ack_i) begin
                  fetch_adr_reg <= fetch_adr_reg + 19'd1;
                  cyc_reg       <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            DRAIN: begin
               // The open cycle must complete; its data is thrown away.
               if (flush_i)
                  fetch_adr_reg <= flush_adr_i;
               if (wbm_ack_i) begin
                  cyc_reg   <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               cyc_reg   <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         dat_mem[wr_ptr_reg] <= wbm_dat_i;
         adr_mem[wr_ptr_reg] <= wbm_adr_reg;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign q_valid_o = (count_reg != '0);
   assign q_dat_o   = dat_mem[rd_ptr_reg];
   assign q_adr_o   = adr_mem[rd_ptr_reg];
   assign q_count_o = count_reg;
   assign wbm_adr_o = wbm_adr_reg;
   assign wbm_sel_o = 2'b11;
   assign wbm_cyc_o = cyc_reg;
   assign wbm_stb_o = cyc_reg;

endmodule

// File: tb/tb_zet_fetch_prefetch.sv
// Randomized bench for zet_fetch_prefetch against a transaction-level queue model.
module tb_zet_fetch_prefetch;

   localparam int          DL2   = 2;
   localparam int          DEPTH = 4;
   localparam logic [18:0] RADR  = 19'h7FFF8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic [18:0]   flush_adr_i = '0;
   logic          rd_i = 1'b0;
   logic          q_valid_o;
   logic [15:0]   q_dat_o;
   logic [18:0]   q_adr_o;
   logic [DL2:0]  q_count_o;
   logic [18:0]   wbm_adr_o;
   logic [1:0]    wbm_sel_o;
   logic          wbm_cyc_o;
   logic          wbm_stb_o;
   logic [15:0]   wbm_dat_i = '0;
   logic          wbm_ack_i = 1'b0;

   zet_fetch_prefetch #(.DEPTH_LOG2(DL2), .RESET_ADR(RADR)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_adr_i(flush_adr_i),
      .rd_i(rd_i), .q_valid_o(q_valid_o), .q_dat_o(q_dat_o), .q_adr_o(q_adr_o),
      .q_count_o(q_count_o), .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   // Model: queue of fetched words plus the bus transfer currently outstanding.
   logic [18:0] mq_adr [$];
   logic [15:0] mq_dat [$];
   logic        m_cyc = 1'b0;
   logic        m_discard = 1'b0;
   logic [18:0] m_req_adr = '0;
   logic [18:0] m_next_adr = RADR;

   function automatic logic [15:0] mem_word(input logic [18:0] a);
      logic [18:0] t;
      t = a * 19'd40503;
      return t[15:0] ^ {a[18:16], a[18:6]} ^ 16'h5A3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic [18:0] fa,
                       input logic rd, input logic ack);
      int sz;
      @(negedge clk_i);
      rst_i       = r;
      flush_i     = f;
      flush_adr_i = fa;
      rd_i        = rd;
      wbm_ack_i   = ack;
      wbm_dat_i   = mem_word(wbm_adr_o);
      sz = mq_adr.size();
      if (r) begin
         mq_adr.delete(); mq_dat.delete();
         m_cyc = 1'b0; m_discard = 1'b0; m_next_adr = RADR;
      end else if (f) begin
         mq_adr.delete(); mq_dat.delete();
         m_next_adr = fa;
         if (m_cyc && ack)
            $display("xfer adr=%05h dropped (flush)", m_req_adr);
         if (m_cyc && !ack) begin
            m_discard = 1'b1;
         end else begin
            m_cyc = 1'b0; m_discard = 1'b0;
         end
      end else begin
         if (rd && sz > 0) begin
            void'(mq_adr.pop_front());
            void'(mq_dat.pop_front());
         end
         if (m_cyc && ack) begin
            if (!m_discard) begin
               mq_adr.push_back(m_req_adr);
               mq_dat.push_back(mem_word(m_req_adr));
               $display("xfer adr=%05h dat=%04h queued", m_req_adr, mem_word(m_req_adr));
            end else begin
               $display("xfer adr=%05h dropped (drain)", m_req_adr);
            end
            m_cyc = 1'b0; m_discard = 1'b0;
         end else if (!m_cyc && sz < DEPTH) begin
            m_cyc = 1'b1;
            m_req_adr = m_next_adr;
            m_next_adr = m_next_adr + 19'd1;
         end
      end
      @(posedge clk_i);
      #1;
      chk("cyc", 32'(wbm_cyc_o), 32'(m_cyc));
      chk("stb", 32'(wbm_stb_o), 32'(m_cyc));
      chk("sel", 32'(wbm_sel_o), 32'd3);
      if (m_cyc) chk("wbm_adr", 32'(wbm_adr_o), 32'(m_req_adr));
      chk("count", 32'(q_count_o), 32'(mq_adr.size()));
      chk("valid", 32'(q_valid_o), 32'(mq_adr.size() != 0));
      if (mq_adr.size() != 0) begin
         chk("q_adr", 32'(q_adr_o), 32'(mq_adr[0]));
         chk("q_dat", 32'(q_dat_o), 32'(mq_dat[0]));
      end
   endtask

   task automatic wait_cyc();
      for (int i = 0; i < 8; i++) begin
         if (m_cyc) break;
         step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      end
      chk("wait_cyc", 32'(wbm_cyc_o), 32'd1);
   endtask

   initial begin
      // 1: reset then free-running acks, no pops: four words then idle
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk("rst_count", 32'(q_count_o), 32'd0);
      chk("rst_valid", 32'(q_valid_o), 32'd0);
      chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("t1_first_adr", 32'(wbm_adr_o), 32'h7FFF8);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("t1_full", 32'(q_count_o), 32'd4);
      chk("t1_idle", 32'(wbm_cyc_o), 32'd0);
      chk("t1_head", 32'(q_adr_o), 32'h7FFF8);

      // 2: one pop while full allows exactly one more fetch
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      chk("t2_head", 32'(q_adr_o), 32'h7FFF9);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("t2_refetch", 32'(wbm_adr_o), 32'h7FFFC);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("t2_full", 32'(q_count_o), 32'd4);

      // 3: flush while a cycle is open, ack delayed three cycles
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      wait_cyc();
      step(1'b0, 1'b1, 19'h00100, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("t3_held", 32'(wbm_cyc_o), 32'd1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("t3_empty", 32'(q_valid_o), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("t3_new_head", 32'(q_adr_o), 32'h00100);

      // 4: address wrap with continuous pops
      step(1'b0, 1'b1, 19'h7FFFF, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

      // 5: flush, ack and rd in the same cycle
      wait_cyc();
      step(1'b0, 1'b1, 19'h12345, 1'b1, 1'b1);
      chk("t5_count", 32'(q_count_o), 32'd0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("t5_adr", 32'(wbm_adr_o), 32'h12345);

      // 6: reset mid-request, late ack ignored
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk("t6_cyc", 32'(wbm_cyc_o), 32'd0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("t6_restart", 32'(wbm_adr_o), 32'h7FFF8);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [18:0] fa;
         fa = ($urandom_range(0, 3) == 0) ? (19'h7FFFC + 19'($urandom_range(0, 3)))
                                          : 19'($urandom);
         step($urandom_range(0, 499) == 0, $urandom_range(0, 24) == 0, fa,
              1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
